// File: rtl/apb_mem_slave_pkg.sv
// Shared types and default geometry for the APB register-memory slave.
// Imported by the top level, the storage sub-module and the bench.
package apb_mem_slave_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;

    typedef logic [APB_ADDR_WIDTH-1:0] addr_t;
    typedef logic [APB_DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_mem_regfile.sv
// Word-addressed storage: synchronous clear on reset, one write port and
// one registered read port whose output holds between read strobes.
module apb_mem_regfile
    import apb_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_mem_slave.sv
// Zero-wait-state APB slave in front of apb_mem_regfile. Holds the
// IDLE/SETUP/ACCESS tracker and decodes the write and read strobes.
module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output apb_state_e            o_dbg_state
);

    // Handshake: a transfer is one cycle with psel=1,penable=0 (setup)
    // followed by one cycle with psel=1,penable=1 (access). There is no
    // PREADY, so every access completes in the cycle it is presented.
    apb_state_e r_state;
    apb_state_e w_next_state;
    logic       w_we;
    logic       w_re;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = (psel && !penable) ? SETUP  : IDLE;
            SETUP:   w_next_state = (psel &&  penable) ? ACCESS : IDLE;
            ACCESS:  w_next_state = (psel && !penable) ? SETUP  : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Writes commit on the access edge; reads are captured on the setup
    // edge so prdata is already stable during the access cycle.
    assign w_we = (r_state == SETUP) && psel && penable && pwrite;
    assign w_re = (r_state != SETUP) && psel && !penable && !pwrite;

    apb_mem_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .i_clk   (pclk),
        .i_rst_n (rst_n),
        .i_we    (w_we),
        .i_waddr (paddr),
        .i_wdata (pwdata),
        .i_re    (w_re),
        .i_raddr (paddr),
        .o_rdata (prdata)
    );

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: directed scenarios plus random
// transfers checked against a word-array model of the memory.
module tb_apb_mem_slave;
  import apb_mem_slave_pkg::*;

  logic       pclk = 1'b0;
  logic       rst_n;
  addr_t      paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  data_t      pwdata;
  data_t      prdata;
  apb_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  data_t ref_mem [256];
  data_t ref_prdata;
  data_t exp_q[$];

  always #5 pclk = ~pclk;

  apb_mem_slave dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    ref_prdata = '0;
    exp_q.delete();
  endtask

  // Inputs change on the falling edge; outputs are sampled there too,
  // reflecting every rising edge that has already happened.
  task automatic go_idle();
    @(negedge pclk);
    check("idle_hold", prdata, ref_prdata);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // One transfer. abort=1 drops psel instead of issuing the access phase
  // (only meaningful for writes; a read has already captured at setup).
  task automatic xfer(input logic wr, input addr_t a, input data_t d, input bit abort);
    data_t e;
    @(negedge pclk);
    check("setup_hold", prdata, ref_prdata);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    if (!wr) exp_q.push_back(ref_mem[a]);
    @(negedge pclk);
    if (abort) begin
      psel = 1'b0; penable = 1'b0;
    end else if (!wr) begin
      penable = 1'b1;
      e = exp_q.pop_front();
      check("rd_data", prdata, e);
      ref_prdata = e;
    end else begin
      penable = 1'b1;
      check("wr_hold", prdata, ref_prdata);
      ref_mem[a] = d;
    end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    xfer(1'b0, 8'h10, '0, 1'b0);
    go_idle();

    // Single write then read.
    xfer(1'b1, 8'h05, 32'hDEADBEEF, 1'b0);
    go_idle();
    xfer(1'b0, 8'h05, '0, 1'b0);
    check("single_rd", prdata, 32'hDEADBEEF);
    go_idle();

    // Back-to-back writes then back-to-back reads, no idle gap.
    xfer(1'b1, 8'h01, 32'h11111111, 1'b0);
    xfer(1'b1, 8'h02, 32'h22222222, 1'b0);
    xfer(1'b1, 8'hFF, 32'hA5A5A5A5, 1'b0);
    xfer(1'b0, 8'h01, '0, 1'b0);
    xfer(1'b0, 8'h02, '0, 1'b0);
    xfer(1'b0, 8'hFF, '0, 1'b0);
    check("b2b_last", prdata, 32'hA5A5A5A5);
    go_idle();

    // Read directly after a write to the same address.
    xfer(1'b1, 8'h20, 32'h0BADF00D, 1'b0);
    xfer(1'b0, 8'h20, '0, 1'b0);
    go_idle();

    // Aborted write: setup, then psel dropped.
    xfer(1'b1, 8'h07, 32'h12345678, 1'b1);
    go_idle();
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    xfer(1'b0, 8'h07, '0, 1'b0);
    go_idle();

    // Protocol violation: access strobe straight from IDLE.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hFFFF0000;
    @(negedge pclk);
    check("viol_prdata", prdata, ref_prdata);
    check("viol_state", 32'(dbg_state), 32'(IDLE));
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    go_idle();
    xfer(1'b0, 8'h08, '0, 1'b0);
    go_idle();

    // Reset in the access phase of a transfer following a write.
    xfer(1'b1, 8'h03, 32'hCAFEF00D, 1'b0);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h55555555;
    @(negedge pclk);
    penable = 1'b1; rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_reset();
    check("mid_rst_prdata", prdata, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    xfer(1'b0, 8'h03, '0, 1'b0);
    xfer(1'b0, 8'h04, '0, 1'b0);
    go_idle();

    // Random traffic over a small address window plus the top word.
    for (int n = 0; n < 150; n++) begin
      addr_t a;
      logic  wr;
      bit    ab;
      a  = ($urandom_range(0, 7) == 0) ? 8'hFF : addr_t'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      ab = wr && ($urandom_range(0, 7) == 0);
      xfer(wr, a, $urandom, ab);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
